// File: rtl/grid_mem_dbuf.sv
// grid_mem_dbuf
// Double-buffered Conway grid memory. The front bank feeds the VGA renderer
// and the cell selector; the selector writes the next generation into the
// back bank. A swap exchanges the banks; a built-in sequencer clears the grid
// or loads the debug seed pattern into both banks, one row per cycle.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset (starts a CLEAR)
//   debug               pulse: load seed pattern into both banks
//   clear               pulse: zero both banks
//   swap                pulse: exchange front/back banks
//   array_in_vga        VGA read row (front bank)
//   alive_out_vga       VGA read data, 1-cycle latency
//   array_selector      selector row (read front, write back)
//   alive_in_selector   selector write data
//   write_enb           write alive_in_selector to back[array_selector]
//   alive_out_selector  selector read data, 1-cycle latency
//   busy                sequencer (clear/load) active
//   front_sel           physical front bank (0 = bank A)
//   generation          completed swaps, wraps mod 2^GEN_W
module grid_mem_dbuf #(
  parameter int WIDTH  = 16,
  parameter int ROWS   = 4,
  parameter int GEN_W  = 8,
  localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug,
  input  logic              clear,
  input  logic              swap,
  input  logic [ADDR_W-1:0] array_in_vga,
  output logic [WIDTH-1:0]  alive_out_vga,
  input  logic [ADDR_W-1:0] array_selector,
  input  logic [WIDTH-1:0]  alive_in_selector,
  input  logic              write_enb,
  output logic [WIDTH-1:0]  alive_out_selector,
  output logic              busy,
  output logic              front_sel,
  output logic [GEN_W-1:0]  generation
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row, row_nxt;

  logic [WIDTH-1:0]  bank_a [ROWS];
  logic [WIDTH-1:0]  bank_b [ROWS];

  logic              seq_we;
  logic [WIDTH-1:0]  seq_data;
  logic              cmd_ok;
  logic              sel_we;
  logic              do_swap;
  logic              vga_ok, sel_ok;
  logic              row_last;

  // Seed base word repeats every four rows; it is replicated across the row
  // and the WIDTH least-significant bits are kept.
  function automatic logic [WIDTH-1:0] seed_row(input logic [ADDR_W-1:0] r);
    logic [31:0] idx;
    logic [15:0] base;
    idx = 32'(r);
    case (idx[1:0])
      2'd0:    base = 16'hC813;
      2'd1:    base = 16'h338C;
      2'd2:    base = 16'h33CC;
      default: base = 16'h6186;
    endcase
    return WIDTH'({(WIDTH / 16 + 1){base}});
  endfunction

  assign vga_ok   = int'(array_in_vga) < ROWS;
  assign sel_ok   = int'(array_selector) < ROWS;
  assign row_last = (row == ADDR_W'(ROWS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      row   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
    end
  end

  // Next state: debug/clear restart their sequence at row 0, even mid-sequence
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    if (debug) begin
      state_nxt = S_LOAD;
      row_nxt   = '0;
    end else if (clear) begin
      state_nxt = S_CLEAR;
      row_nxt   = '0;
    end else if (state != S_IDLE) begin
      if (row_last) begin
        state_nxt = S_IDLE;
        row_nxt   = '0;
      end else begin
        row_nxt = row + 1'b1;
      end
    end
  end

  // Outputs: selector write and swap only when idle and not pre-empted by a
  // higher-priority command on the same edge
  always_comb begin
    busy     = (state != S_IDLE);
    seq_we   = busy && !rst;
    seq_data = (state == S_LOAD) ? seed_row(row) : '0;
    cmd_ok   = !busy && !rst && !debug && !clear;
    sel_we   = cmd_ok && write_enb && sel_ok;
    do_swap  = cmd_ok && swap;
  end

  // Banks: sequencer writes both; selector writes whichever is back now, so a
  // write coinciding with a swap lands in the bank that becomes front.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      bank_a[row] <= seq_data;
      bank_b[row] <= seq_data;
    end
    if (sel_we) begin
      if (front_sel) bank_a[array_selector] <= alive_in_selector;
      else           bank_b[array_selector] <= alive_in_selector;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel  <= 1'b0;
      generation <= '0;
    end else if (do_swap) begin
      front_sel  <= !front_sel;
      generation <= generation + 1'b1;
    end
  end

  // Registered reads use the pre-edge front_sel, so reads on a swap edge
  // still see the old front.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_out_vga      <= '0;
      alive_out_selector <= '0;
    end else begin
      if (!vga_ok)        alive_out_vga <= '0;
      else if (front_sel) alive_out_vga <= bank_b[array_in_vga];
      else                alive_out_vga <= bank_a[array_in_vga];
      if (!sel_ok)        alive_out_selector <= '0;
      else if (front_sel) alive_out_selector <= bank_b[array_selector];
      else                alive_out_selector <= bank_a[array_selector];
    end
  end

endmodule

// File: tb/tb_grid_mem_dbuf.sv
// Bench for grid_mem_dbuf: random and directed stimulus against a logical
// front/back grid model; expectations queued per edge, popped by a monitor.
// A second small instance (ROWS=6, WIDTH=8, GEN_W=2) covers odd geometry.
module tb_grid_mem_dbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, debug = 1'b0, clear = 1'b0, swap = 1'b0, write_enb = 1'b0;
  logic [1:0]  array_in_vga = '0, array_selector = '0;
  logic [15:0] alive_in_selector = '0;
  logic [15:0] alive_out_vga, alive_out_selector;
  logic        busy, front_sel;
  logic [7:0]  generation;

  grid_mem_dbuf u_dut (
    .clk(clk), .rst(rst), .debug(debug), .clear(clear), .swap(swap),
    .array_in_vga(array_in_vga), .alive_out_vga(alive_out_vga),
    .array_selector(array_selector), .alive_in_selector(alive_in_selector),
    .write_enb(write_enb), .alive_out_selector(alive_out_selector),
    .busy(busy), .front_sel(front_sel), .generation(generation)
  );

  logic       s_rst = 1'b0, s_debug = 1'b0, s_clear = 1'b0, s_swap = 1'b0, s_we = 1'b0;
  logic [2:0] s_av = '0, s_as = '0;
  logic [7:0] s_in = '0, s_vga, s_sel;
  logic       s_busy, s_fs;
  logic [1:0] s_gen;

  grid_mem_dbuf #(.WIDTH(8), .ROWS(6), .GEN_W(2)) u_small (
    .clk(clk), .rst(s_rst), .debug(s_debug), .clear(s_clear), .swap(s_swap),
    .array_in_vga(s_av), .alive_out_vga(s_vga),
    .array_selector(s_as), .alive_in_selector(s_in),
    .write_enb(s_we), .alive_out_selector(s_sel),
    .busy(s_busy), .front_sel(s_fs), .generation(s_gen)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: logical front/back grids, swapped by content
  logic [15:0] SEED [4] = '{16'hC813, 16'h338C, 16'h33CC, 16'h6186};
  logic [15:0] mf [4], mb [4];
  bit          kf [4], kb [4];   // row contents known (written since sim start)
  int          seq  = 0;         // 0 idle, 1 clearing, 2 loading
  int          srow = 0;
  bit          flag = 0;
  logic [7:0]  gen  = '0;

  typedef struct {
    logic [15:0] vga; bit kv;
    logic [15:0] sel; bit ks;
    bit busy; bit fs; logic [7:0] gen;
  } exp_t;
  exp_t q[$];

  initial for (int i = 0; i < 4; i++) begin kf[i] = 0; kb[i] = 0; mf[i] = '0; mb[i] = '0; end

  function automatic void swap_grids();
    logic [15:0] t; bit k;
    for (int i = 0; i < 4; i++) begin
      t = mf[i]; mf[i] = mb[i]; mb[i] = t;
      k = kf[i]; kf[i] = kb[i]; kb[i] = k;
    end
  endfunction

  task automatic step(input bit r, input bit d, input bit c, input bit s, input bit w,
                      input int wa, input logic [15:0] wd, input int av, input int as);
    exp_t e;
    bit   was_busy;
    @(negedge clk);
    rst = r; debug = d; clear = c; swap = s; write_enb = w;
    array_selector = 2'(as); array_in_vga = 2'(av); alive_in_selector = wd;
    was_busy = (seq != 0);
    e.vga = mf[av]; e.kv = kf[av];
    e.sel = mf[as]; e.ks = kf[as];
    if (r) begin
      // physical bank A is front again after reset
      if (flag) swap_grids();
      flag = 0; gen = '0; seq = 1; srow = 0;
      e.vga = '0; e.kv = 1; e.sel = '0; e.ks = 1;
    end else begin
      if (was_busy) begin
        mf[srow] = (seq == 2) ? SEED[srow] : 16'h0000;
        mb[srow] = mf[srow];
        kf[srow] = 1; kb[srow] = 1;
      end
      if (!was_busy && !d && !c) begin
        if (w) begin mb[as] = wd; kb[as] = 1; end
        if (s) begin swap_grids(); flag = !flag; gen = gen + 8'd1; end
      end
      if (d) begin seq = 2; srow = 0; end
      else if (c) begin seq = 1; srow = 0; end
      else if (was_busy) begin
        if (srow == 3) seq = 0; else srow++;
      end
    end
    e.busy = (seq != 0); e.fs = flag; e.gen = gen;
    q.push_back(e);
  endtask

  task automatic rd(input int av, input int as);
    step(0, 0, 0, 0, 0, 0, 16'h0, av, as);
  endtask

  // Monitor: outputs are presented every cycle; one expectation per edge
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("front_sel", 32'(front_sel), 32'(e.fs));
      chk("generation", 32'(generation), 32'(e.gen));
      if (e.kv) chk("vga_data", 32'(alive_out_vga), 32'(e.vga));
      if (e.ks) chk("sel_data", 32'(alive_out_selector), 32'(e.sel));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // reset, CLEAR sweep, zero readback
    step(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) rd(i % 4, 3 - (i % 4));
    // debug load, seed readback on both ports
    step(0, 1, 0, 0, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) rd(i, i);
    for (int i = 0; i < 4; i++) rd(3 - i, i);
    // write back, front unchanged until swap
    step(0, 0, 0, 0, 1, 2, 16'hA5A5, 2, 2);
    rd(2, 2);
    step(0, 0, 0, 1, 0, 0, 16'h0, 2, 2);
    rd(2, 2);
    // write + swap on the same edge
    step(0, 0, 0, 1, 1, 1, 16'h1234, 1, 1);
    rd(1, 1);
    rd(1, 1);
    // clear, debug restart mid-sequence, write/swap while busy dropped
    step(0, 0, 1, 0, 0, 0, 16'h0, 0, 0);
    rd(0, 1);
    step(0, 1, 0, 0, 0, 0, 16'h0, 2, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, i % 4, 16'hFFFF, i % 4, 3 - (i % 4));
    for (int i = 0; i < 4; i++) rd(i, 3 - i);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(199) == 0, $urandom_range(59) == 0, $urandom_range(59) == 0,
           $urandom_range(7) == 0, $urandom_range(1) == 0,
           int'($urandom_range(3)), 16'($urandom), int'($urandom_range(3)), int'($urandom_range(3)));
    end
    rd(0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    // small instance: ROWS=6 clear length, seed truncation, bad address, gen wrap
    @(negedge clk); s_rst = 1'b1;
    @(negedge clk); s_rst = 1'b0;
    cnt = 0;
    while (s_busy && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("small_clear_cycles", 32'(cnt), 32'd6);
    @(negedge clk); s_debug = 1'b1;
    @(negedge clk); s_debug = 1'b0;
    cnt = 0;
    while (s_busy && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("small_load_done", 32'(s_busy), 32'd0);
    @(negedge clk); s_av = 3'd4; s_as = 3'd5;
    @(posedge clk); #1;
    chk("small_vga_row4", 32'(s_vga), 32'h13);
    chk("small_sel_row5", 32'(s_sel), 32'h8C);
    @(negedge clk); s_av = 3'd7; s_as = 3'd6; s_we = 1'b1; s_in = 8'hFF;
    @(posedge clk); #1;
    chk("small_vga_addr7", 32'(s_vga), 32'h00);
    chk("small_sel_addr6", 32'(s_sel), 32'h00);
    @(negedge clk); s_we = 1'b0; s_av = 3'd0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); s_swap = 1'b1;
      @(posedge clk); #1;
      chk("small_generation", 32'(s_gen), 32'(i % 4));
      chk("small_front_sel", 32'(s_fs), 32'(i % 2));
    end
    @(negedge clk); s_swap = 1'b0;
    @(posedge clk); #1;
    chk("small_row0_seed", 32'(s_vga), 32'h13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
